// File: rtl/avalon_copier_pkg.sv
`default_nettype none
// ============================================================================
// Module  : avalon_copier_pkg
// Purpose : Shared types and constants for the Avalon-MM word copier.
//           - state_e    : copier FSM states
//           - WORD_BYTES : byte stride between consecutive 32-bit words
//           - BE_ALL     : byte-enable pattern for full-word accesses
// Revision: 1.0 - initial release
// ============================================================================
package avalon_copier_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  localparam int unsigned WORD_BYTES = 4;
  localparam logic [3:0]  BE_ALL     = 4'hF;

endpackage : avalon_copier_pkg
`default_nettype wire

// File: rtl/avalon_mm_word_copier.sv
`default_nettype none
// ============================================================================
// Module  : avalon_mm_word_copier
// Purpose : Avalon-MM master that copies COUNT 32-bit words from a source
//           byte address to a destination byte address, one outstanding
//           transaction at a time (read word, write word, repeat), and
//           accumulates a modulo-2^32 checksum of every word read.
// Ports   :
//   clk, reset_n                  clock, asynchronous active-low reset
//   start                         one-cycle copy request (honoured in IDLE)
//   src_addr, dst_addr            word-aligned byte addresses (bits[1:0] ignored)
//   count                         number of words to copy
//   busy, done                    status: busy through DONE, done one-cycle pulse
//   checksum                      running sum of words read by current/last copy
//   avm_*                         Avalon-MM master port
// Revision: 1.0 - initial release
// ============================================================================
module avalon_mm_word_copier
  import avalon_copier_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [CNT_W-1:0]  count,
  output logic              busy,
  output logic              done,
  output logic [31:0]       checksum,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  input  logic              avm_waitrequest
);

  // Clears the byte-offset bits so pointers always land on word boundaries.
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(WORD_BYTES - 1);
  localparam logic [ADDR_W-1:0] STRIDE     = ADDR_W'(WORD_BYTES);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_q,   src_d;
  logic [ADDR_W-1:0] dst_q,   dst_d;
  logic [CNT_W-1:0]  rem_q,   rem_d;
  logic [31:0]       data_q,  data_d;
  logic [31:0]       sum_q,   sum_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      sum_q   <= sum_d;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    data_d  = data_q;
    sum_d   = sum_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          src_d   = src_addr & ALIGN_MASK;
          dst_d   = dst_addr & ALIGN_MASK;
          rem_d   = count;
          sum_d   = '0;
          state_d = (count == '0) ? ST_DONE : ST_RD_REQ;
        end
      end

      ST_RD_REQ: begin
        if (!avm_waitrequest) begin
          state_d = ST_RD_WAIT;
        end
      end

      // readdatavalid is only honoured here, never in the acceptance cycle.
      ST_RD_WAIT: begin
        if (avm_readdatavalid) begin
          data_d  = avm_readdata;
          sum_d   = sum_q + avm_readdata;
          state_d = ST_WR_REQ;
        end
      end

      ST_WR_REQ: begin
        if (!avm_waitrequest) begin
          src_d   = src_q + STRIDE;
          dst_d   = dst_q + STRIDE;
          rem_d   = rem_q - CNT_W'(1);
          // rem_q still holds the pre-decrement value: 1 means last word.
          state_d = (rem_q == CNT_W'(1)) ? ST_DONE : ST_RD_REQ;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Bus outputs decode straight from the state register so that an
  // asserted reset_n drops read/write without waiting for a clock edge.
  assign avm_read       = (state_q == ST_RD_REQ);
  assign avm_write      = (state_q == ST_WR_REQ);
  assign avm_address    = avm_read  ? src_q :
                          avm_write ? dst_q : '0;
  assign avm_writedata  = avm_write ? data_q : '0;
  assign avm_byteenable = (avm_read || avm_write) ? BE_ALL : 4'h0;

  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign checksum = sum_q;

endmodule : avalon_mm_word_copier
`default_nettype wire
